intcontrol_pri: RTL
===================

// Module: intcontrol_pri
// PURPOSE
//  Parametrised Wishbone-slave interrupt controller; successor to the 8-input fixed-priority encoder.
//  Collects NUM_IRQ external request lines with per-line edge/level mode, pending latch, and mask.
//  Drives one CPU interrupt line and exposes the highest-priority active source ID.
//  Sits on the peripheral Wishbone bus beside the other SoC slaves.
// PARAMETERS
//  NUM_IRQ  8  number of request lines, 2..DAT_W
//  DAT_W    8  Wishbone data width, 8..32
//  ID_W     3  source ID width, must be >= clog2(NUM_IRQ) and <= DAT_W-1
// PORTS
//  CLK_I          in   1        system clock
//  RST_I          in   1        synchronous active-high reset
//  CYC_I          in   1        Wishbone cycle
//  STB_I          in   1        Wishbone strobe
//  WE_I           in   1        Wishbone write enable
//  ADR_I          in   2        register select
//  DAT_I          in   DAT_W    write data
//  ACK_O          out  1        Wishbone acknowledge
//  DAT_O          out  DAT_W    read data
//  ext_irq_bus_i  in   NUM_IRQ  request lines, active high
//  irq_o          out  1        interrupt to CPU, registered
// BEHAVIOUR
//  One clock CLK_I; reset synchronous active-high on RST_I.
//  Reset: ACK_O=0, DAT_O=0, irq_o=0, PEND=0, MASK=0 (all disabled), MODE=0 (all level), edge history=0.
//  Bus: ACK_O <= CYC_I & STB_I & ~ACK_O. Each access acked 1 cycle after request; ACK_O is high at most 1 cycle.
//  Read: DAT_O is registered on the same edge as ACK_O. Write: commits on the same edge as ACK_O.
//  Register map (ADR_I), bits above NUM_IRQ read 0 and ignore writes:
//   0 STATUS  R   [DAT_W-1]=valid (any PEND&MASK), [ID_W-1:0]=ID of the highest active line; other bits 0.
//                 Writes are ignored.
//   1 PEND    R/W1C  pending vector. Writing 1 clears edge-mode bits. Has no effect on level-mode bits.
//   2 MASK    RW  1=line enabled.
//   3 MODE    RW  1=rising-edge, 0=level.
//  Level line: PEND[i] = registered ext_irq_bus_i[i], following the input with 1-cycle delay.
//  Edge line: PEND[i] is set when in[i]=1 and the previous sample is 0, and stays set until W1C.
//  Simultaneous edge and W1C on the same bit: the set wins; the bit stays 1.
//  MODE change level->edge: PEND[i] is cleared on the write edge. Edge history keeps sampling in every mode.
//  Priority: highest index wins (line NUM_IRQ-1 highest). If none is active: ID=0, valid=0.
//  irq_o <= |(PEND & MASK). Input edge -> PEND in 1 cycle -> irq_o in 1 more cycle (2 total).
//  Masked lines still latch PEND. Unmasking a pending line raises irq_o 1 cycle after the MASK write.
//  STATUS ID is computed from current PEND & MASK, so a read reflects state at the request cycle.
//  RST_I mid-access: ACK_O drops next edge and the write is discarded; the master must retry.
//  CYC_I or STB_I dropping before the ack: no write is committed. An ack that is already registered is still emitted.
// CONFIGURATION
//  INTC_SYNC_EN defined: each ext_irq_bus_i bit passes through a 2-flop synchroniser before edge/level logic.
//   Input -> irq_o latency becomes 4 cycles. Synchroniser flops reset to 0.
//  INTC_SYNC_EN undefined: inputs are used directly and must be synchronous to CLK_I. Latency is 2 cycles.
// TESTING
//  Reset, then read ADR 0..3 -> DAT_O=0 for all; irq_o=0; each ACK_O is high exactly 1 cycle after STB_I.
//  MODE=0, MASK=0xFF, drive ext=0x24 -> irq_o=1 after 2 cycles; STATUS=0x85; drop ext -> irq_o=0 after 2 cycles.
//  MODE=0xFF, MASK=0x01, pulse ext[0] for 1 cycle -> PEND=0x01, irq_o=1. Write PEND=0x01 -> PEND=0, irq_o=0.
//  Edge on ext[3] in the same cycle as W1C of bit 3 -> PEND[3] stays 1.
//  MASK=0, edge on ext[6] -> PEND=0x40, irq_o=0; write MASK=0x40 -> irq_o=1 next cycle, STATUS=0x86.
//  Assert RST_I during a write to MASK -> MASK=0 after reset; no ACK_O in the following cycle.

Source files
------------

// File: rtl/intcontrol_pri.sv
// intcontrol_pri: Wishbone-slave interrupt controller with per-line edge/level mode, pending latch, mask and highest-index priority.
// Define INTC_SYNC_EN to add a 2-flop synchroniser on every request line.
module intcontrol_pri #(
  parameter int NUM_IRQ = 8,
  parameter int DAT_W   = 8,
  parameter int ID_W    = 3
) (
  input  logic               CLK_I,
  input  logic               RST_I,
  input  logic               CYC_I,
  input  logic               STB_I,
  input  logic               WE_I,
  input  logic [1:0]         ADR_I,
  input  logic [DAT_W-1:0]   DAT_I,
  output logic               ACK_O,
  output logic [DAT_W-1:0]   DAT_O,
  input  logic [NUM_IRQ-1:0] ext_irq_bus_i,
  output logic               irq_o
);
  logic [NUM_IRQ-1:0] r_pend, r_mask, r_mode, r_prev;
  logic [NUM_IRQ-1:0] w_in, w_dat, w_act, w_rise, w_clr, w_mode_on, w_pend_nx;
  logic [ID_W-1:0]    w_id;
  logic [DAT_W-1:0]   w_status, w_rdata;
  logic               w_req, w_wr;
`ifdef INTC_SYNC_EN
  logic [NUM_IRQ-1:0] r_sync1, r_sync2;
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= ext_irq_bus_i;
      r_sync2 <= r_sync1;
    end
  end
  assign w_in = r_sync2;
`else
  assign w_in = ext_irq_bus_i;
`endif
  assign w_req     = CYC_I & STB_I & ~ACK_O;
  assign w_wr      = w_req & WE_I;
  assign w_dat     = DAT_I[NUM_IRQ-1:0];
  assign w_rise    = w_in & ~r_prev;
  assign w_clr     = (w_wr && ADR_I == 2'd1) ? w_dat : '0;
  assign w_mode_on = (w_wr && ADR_I == 2'd3) ? (w_dat & ~r_mode) : '0;
  // A rising edge beats a simultaneous W1C; switching a line to edge mode drops its stale level state.
  assign w_pend_nx = ~w_mode_on & ((r_mode & (w_rise | (r_pend & ~w_clr))) | (~r_mode & w_in));
  assign w_act     = r_pend & r_mask;
  always_comb begin
    w_id = '0;
    for (int i = 0; i < NUM_IRQ; i++)
      if (w_act[i]) w_id = ID_W'(i);
  end
  always_comb begin
    w_status = '0;
    w_status[DAT_W-1] = |w_act;
    w_status[ID_W-1:0] = w_id;
  end
  assign w_rdata = (ADR_I == 2'd0) ? w_status :
                   (ADR_I == 2'd1) ? DAT_W'(r_pend) :
                   (ADR_I == 2'd2) ? DAT_W'(r_mask) : DAT_W'(r_mode);
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      ACK_O  <= 1'b0;
      DAT_O  <= '0;
      irq_o  <= 1'b0;
      r_pend <= '0;
      r_mask <= '0;
      r_mode <= '0;
      r_prev <= '0;
    end else begin
      ACK_O  <= w_req;
      irq_o  <= |w_act;
      r_prev <= w_in;
      r_pend <= w_pend_nx;
      if (w_req && !WE_I) DAT_O <= w_rdata;
      if (w_wr && ADR_I == 2'd2) r_mask <= w_dat;
      if (w_wr && ADR_I == 2'd3) r_mode <= w_dat;
    end
  end
endmodule
